// File: rtl/bdram_dp.sv
// Dual-port block RAM: port A byte-strobed read/write, port B read-only, 1-cycle registered reads.
// Define BDRAM_INIT_CLEAR_EN to zero-fill the array after every reset before init_done rises.
module bdram_dp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int RD_MODE = 0
) (
    input  logic                clka,
    input  logic                resetn,
    output logic                init_done,
    input  logic                a_en,
    input  logic [DATA_W/8-1:0] a_we,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_din,
    output logic [DATA_W-1:0]   a_dout,
    output logic                a_valid,
    input  logic                b_en,
    input  logic [ADDR_W-1:0]   b_addr,
    output logic [DATA_W-1:0]   b_dout,
    output logic                b_valid
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     we
    );
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            if (we[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    // Stage p0: request decode and word selection
    logic              a_acc_p0, a_wr_p0, b_acc_p0, b_hit_p0;
    logic [DATA_W-1:0] a_old_p0, b_old_p0, a_new_p0, a_word_p0, b_word_p0;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    assign a_acc_p0 = a_en & init_done;
    assign a_wr_p0  = a_acc_p0 & (|a_we);
    assign b_acc_p0 = b_en & init_done;
    assign b_hit_p0 = b_acc_p0 & a_wr_p0 & (a_addr == b_addr);

    assign a_old_p0 = mem[a_addr];
    assign b_old_p0 = mem[b_addr];
    assign a_new_p0 = merge_bytes(a_old_p0, a_din, a_we);

    // Port B sees the same whole word port A reports, never a partial merge.
    assign a_word_p0 = (RD_MODE != 0) ? a_new_p0 : a_old_p0;
    assign b_word_p0 = (RD_MODE != 0 && b_hit_p0) ? a_new_p0 : b_old_p0;

    always_ff @(posedge clka) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (a_wr_p0) begin
            for (int i = 0; i < NB; i++) begin
                if (a_we[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
            end
        end
    end

    // Stage p1: registered read ports
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            a_dout  <= '0;
            a_valid <= 1'b0;
            b_dout  <= '0;
            b_valid <= 1'b0;
        end else begin
            a_valid <= a_acc_p0;
            b_valid <= b_acc_p0;
            if (a_acc_p0) a_dout <= a_word_p0;
            if (b_acc_p0) b_dout <= b_word_p0;
        end
    end

`ifdef BDRAM_INIT_CLEAR_EN
    typedef enum logic {CLEAR, READY} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) begin
            state     <= CLEAR;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_done <= (state_nxt == READY);
            if (state == CLEAR && cnt != '1) cnt <= cnt + 1'b1;
        end
    end

    // Gated by resetn so holding reset never disturbs the array.
    always_comb begin
        state_nxt = state;
        clr_we    = 1'b0;
        case (state)
            CLEAR: begin
                clr_we = resetn;
                if (cnt == '1) state_nxt = READY;
            end
            READY: state_nxt = READY;
            default: state_nxt = CLEAR;
        endcase
    end

    assign clr_addr = cnt;
`else
    always_ff @(posedge clka or negedge resetn) begin
        if (!resetn) init_done <= 1'b0;
        else         init_done <= 1'b1;
    end

    assign clr_we   = 1'b0;
    assign clr_addr = '0;
`endif

endmodule

// File: tb/tb_bdram_dp.sv
// Directed bench for bdram_dp: three instances (32-bit read-first, 32-bit write-first, 64-bit read-first).
module tb_bdram_dp;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic resetn;
    logic init0, init1, init2;

    logic        a_en0, a_valid0, b_en0, b_valid0;
    logic [3:0]  a_we0, a_addr0, b_addr0;
    logic [31:0] a_din0, a_dout0, b_dout0;

    logic        a_en1, a_valid1, b_en1, b_valid1;
    logic [3:0]  a_we1, a_addr1, b_addr1;
    logic [31:0] a_din1, a_dout1, b_dout1;

    logic        a_en2, a_valid2, b_en2, b_valid2;
    logic [7:0]  a_we2;
    logic [3:0]  a_addr2, b_addr2;
    logic [63:0] a_din2, a_dout2, b_dout2;

    int checks = 0;
    int errors = 0;

`ifdef BDRAM_INIT_CLEAR_EN
    localparam int INIT_LAT = 16;
`else
    localparam int INIT_LAT = 1;
`endif

    bdram_dp #(.DATA_W(32), .ADDR_W(4), .RD_MODE(0)) u0 (
        .clka(clka), .resetn(resetn), .init_done(init0),
        .a_en(a_en0), .a_we(a_we0), .a_addr(a_addr0), .a_din(a_din0),
        .a_dout(a_dout0), .a_valid(a_valid0),
        .b_en(b_en0), .b_addr(b_addr0), .b_dout(b_dout0), .b_valid(b_valid0));

    bdram_dp #(.DATA_W(32), .ADDR_W(4), .RD_MODE(1)) u1 (
        .clka(clka), .resetn(resetn), .init_done(init1),
        .a_en(a_en1), .a_we(a_we1), .a_addr(a_addr1), .a_din(a_din1),
        .a_dout(a_dout1), .a_valid(a_valid1),
        .b_en(b_en1), .b_addr(b_addr1), .b_dout(b_dout1), .b_valid(b_valid1));

    bdram_dp #(.DATA_W(64), .ADDR_W(4), .RD_MODE(0)) u2 (
        .clka(clka), .resetn(resetn), .init_done(init2),
        .a_en(a_en2), .a_we(a_we2), .a_addr(a_addr2), .a_din(a_din2),
        .a_dout(a_dout2), .a_valid(a_valid2),
        .b_en(b_en2), .b_addr(b_addr2), .b_dout(b_dout2), .b_valid(b_valid2));

    task automatic tick;
        @(posedge clka);
        #1;
    endtask

    task automatic idle_all;
        a_en0 = 0; a_we0 = '0; a_addr0 = '0; a_din0 = '0; b_en0 = 0; b_addr0 = '0;
        a_en1 = 0; a_we1 = '0; a_addr1 = '0; a_din1 = '0; b_en1 = 0; b_addr1 = '0;
        a_en2 = 0; a_we2 = '0; a_addr2 = '0; a_din2 = '0; b_en2 = 0; b_addr2 = '0;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init0 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset;
        int n;
        resetn = 0;
        idle_all();
        tick();
        tick();
        checks++; if (a_dout0 !== 32'h0) begin errors++; $display("FAIL rst_a_dout got %h want 0", a_dout0); end
        checks++; if (b_dout0 !== 32'h0) begin errors++; $display("FAIL rst_b_dout got %h want 0", b_dout0); end
        checks++; if ({a_valid0, b_valid0} !== 2'b00) begin errors++; $display("FAIL rst_valid got %b want 00", {a_valid0, b_valid0}); end
        checks++; if (init0 !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b want 0", init0); end
        resetn = 1;
        wait_init(n);
        checks++; if (n != INIT_LAT) begin errors++; $display("FAIL init_latency got %0d want %0d", n, INIT_LAT); end
        checks++; if ({init1, init2} !== 2'b11) begin errors++; $display("FAIL init_others got %b want 11", {init1, init2}); end
    endtask

    task automatic test_byte_write;
        a_en0 = 1; a_we0 = 4'hF; a_addr0 = 4'd3; a_din0 = 32'h11223344;
        tick();
        a_we0 = 4'b0101; a_din0 = 32'hAABBCCDD;
        tick();
        checks++; if (a_dout0 !== 32'h11223344) begin errors++; $display("FAIL bw_prewrite got %h want 11223344", a_dout0); end
        a_we0 = 4'h0; a_din0 = 32'h0;
        tick();
        checks++; if (a_dout0 !== 32'h11BB33DD) begin errors++; $display("FAIL bw_read got %h want 11bb33dd", a_dout0); end
        checks++; if (a_valid0 !== 1'b1) begin errors++; $display("FAIL bw_valid got %b want 1", a_valid0); end
        a_en0 = 0;
        tick();
        checks++; if (a_valid0 !== 1'b0) begin errors++; $display("FAIL bw_idle_valid got %b want 0", a_valid0); end
        checks++; if (a_dout0 !== 32'h11BB33DD) begin errors++; $display("FAIL bw_hold got %h want 11bb33dd", a_dout0); end
    endtask

    task automatic test_rdw;
        a_en0 = 1; a_we0 = 4'hF; a_addr0 = 4'd5; a_din0 = 32'h00000001;
        a_en1 = 1; a_we1 = 4'hF; a_addr1 = 4'd5; a_din1 = 32'h00000001;
        tick();
        a_din0 = 32'hDEADBEEF; a_din1 = 32'hDEADBEEF;
        tick();
        checks++; if (a_dout0 !== 32'h00000001) begin errors++; $display("FAIL rdw_rf got %h want 00000001", a_dout0); end
        checks++; if (a_dout1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rdw_wf got %h want deadbeef", a_dout1); end
        checks++; if (a_valid1 !== 1'b1) begin errors++; $display("FAIL rdw_wf_valid got %b want 1", a_valid1); end
        a_we0 = 4'h0; a_we1 = 4'h0;
        tick();
        checks++; if (a_dout0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rdw_rf_after got %h want deadbeef", a_dout0); end
        checks++; if (a_dout1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rdw_wf_after got %h want deadbeef", a_dout1); end
        a_we0 = 4'b0011; a_din0 = 32'h00001234;
        a_we1 = 4'b0011; a_din1 = 32'h00001234;
        tick();
        checks++; if (a_dout0 !== 32'hDEADBEEF) begin errors++; $display("FAIL rdw_rf_part got %h want deadbeef", a_dout0); end
        checks++; if (a_dout1 !== 32'hDEAD1234) begin errors++; $display("FAIL rdw_wf_part got %h want dead1234", a_dout1); end
        idle_all();
        tick();
    endtask

    task automatic test_collision;
        a_en0 = 1; a_we0 = 4'hF; a_addr0 = 4'd7; a_din0 = 32'hFFFFFFFF;
        a_en1 = 1; a_we1 = 4'hF; a_addr1 = 4'd7; a_din1 = 32'hFFFFFFFF;
        tick();
        a_din0 = 32'h12345678; b_en0 = 1; b_addr0 = 4'd7;
        a_din1 = 32'h12345678; b_en1 = 1; b_addr1 = 4'd7;
        tick();
        checks++; if (b_dout0 !== 32'hFFFFFFFF) begin errors++; $display("FAIL col_rf got %h want ffffffff", b_dout0); end
        checks++; if (b_dout1 !== 32'h12345678) begin errors++; $display("FAIL col_wf got %h want 12345678", b_dout1); end
        checks++; if ({b_valid0, b_valid1} !== 2'b11) begin errors++; $display("FAIL col_valid got %b want 11", {b_valid0, b_valid1}); end
        a_we0 = 4'b1000; a_din0 = 32'hAB000000;
        a_we1 = 4'b1000; a_din1 = 32'hAB000000;
        tick();
        checks++; if (b_dout0 !== 32'h12345678) begin errors++; $display("FAIL col_rf_part got %h want 12345678", b_dout0); end
        checks++; if (b_dout1 !== 32'hAB345678) begin errors++; $display("FAIL col_wf_part got %h want ab345678", b_dout1); end
        a_en0 = 0; a_en1 = 0;
        tick();
        checks++; if (b_dout0 !== 32'hAB345678) begin errors++; $display("FAIL col_rf_after got %h want ab345678", b_dout0); end
        checks++; if (b_dout1 !== 32'hAB345678) begin errors++; $display("FAIL col_wf_after got %h want ab345678", b_dout1); end
        idle_all();
        tick();
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp;
        for (int i = 0; i < 8; i++) begin
            a_en2 = 1; a_we2 = 8'hFF; a_addr2 = 4'(i); a_din2 = 64'h1111111111111111 * 64'(i + 1);
            tick();
        end
        idle_all();
        b_en2 = 1; b_addr2 = 4'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i < 7) b_addr2 = 4'(i + 1);
            else b_en2 = 0;
            exp = 64'h1111111111111111 * 64'(i + 1);
            checks++;
            if (b_valid2 !== 1'b1 || b_dout2 !== exp) begin
                errors++;
                $display("FAIL b2b_word%0d got %b/%h want 1/%h", i, b_valid2, b_dout2, exp);
            end
        end
        tick();
        checks++; if (b_valid2 !== 1'b0) begin errors++; $display("FAIL b2b_drop_valid got %b want 0", b_valid2); end
        checks++; if (b_dout2 !== 64'h8888888888888888) begin errors++; $display("FAIL b2b_hold got %h want 8888888888888888", b_dout2); end
    endtask

    task automatic test_reset_mid_access;
        int n;
        logic [31:0] exp3;
        a_en0 = 1; a_we0 = 4'hF; a_addr0 = 4'd3; a_din0 = 32'hCAFEF00D;
        #3;
        resetn = 0;
        #1;
        checks++; if (a_dout0 !== 32'h0) begin errors++; $display("FAIL rma_a_dout got %h want 0", a_dout0); end
        checks++; if (b_dout2 !== 64'h0) begin errors++; $display("FAIL rma_b_dout got %h want 0", b_dout2); end
        checks++; if ({init0, a_valid0, b_valid0} !== 3'b000) begin errors++; $display("FAIL rma_ctrl got %b want 000", {init0, a_valid0, b_valid0}); end
        idle_all();
        tick();
        resetn = 1;
        wait_init(n);
        checks++; if (n != INIT_LAT) begin errors++; $display("FAIL rma_latency got %0d want %0d", n, INIT_LAT); end
`ifdef BDRAM_INIT_CLEAR_EN
        exp3 = 32'h0;
`else
        exp3 = 32'h11BB33DD;
`endif
        a_en0 = 1; a_addr0 = 4'd3;
        tick();
        a_en0 = 0;
        checks++; if (a_dout0 !== exp3) begin errors++; $display("FAIL rma_no_write got %h want %h", a_dout0, exp3); end
    endtask

`ifdef BDRAM_INIT_CLEAR_EN
    task automatic preload_a5;
        for (int i = 0; i < 16; i++) begin
            a_en0 = 1; a_we0 = 4'hF; a_addr0 = 4'(i); a_din0 = 32'hA5A5A5A5;
            tick();
        end
        idle_all();
    endtask

    task automatic test_init_clear;
        int  n;
        logic av_seen;
        preload_a5();
        resetn = 0;
        tick();
        resetn = 1;
        n = 0;
        av_seen = 0;
        while (!init0 && n < 100) begin
            tick();
            n++;
            if (a_valid0) av_seen = 1;
            if (n == 2) a_en0 = 1;
            if (n == 5) a_en0 = 0;
        end
        a_en0 = 0;
        checks++; if (n != 16) begin errors++; $display("FAIL clr_latency got %0d want 16", n); end
        checks++; if (av_seen !== 1'b0) begin errors++; $display("FAIL clr_drop got a_valid %b want 0", av_seen); end
        for (int i = 0; i < 16; i++) begin
            a_en0 = 1; a_addr0 = 4'(i);
            tick();
            checks++;
            if (a_valid0 !== 1'b1 || a_dout0 !== 32'h0) begin
                errors++;
                $display("FAIL clr_word%0d got %b/%h want 1/00000000", i, a_valid0, a_dout0);
            end
        end
        idle_all();
        tick();
    endtask

    task automatic test_reset_mid_clear;
        int n;
        preload_a5();
        resetn = 0;
        tick();
        resetn = 1;
        for (int i = 0; i < 9; i++) tick();
        checks++; if (init0 !== 1'b0) begin errors++; $display("FAIL rmc_early_init got %b want 0", init0); end
        resetn = 0;
        #1;
        checks++; if ({a_dout0, b_dout0} !== 64'h0) begin errors++; $display("FAIL rmc_douts got %h want 0", {a_dout0, b_dout0}); end
        checks++; if ({init0, a_valid0, b_valid0} !== 3'b000) begin errors++; $display("FAIL rmc_ctrl got %b want 000", {init0, a_valid0, b_valid0}); end
        tick();
        resetn = 1;
        wait_init(n);
        checks++; if (n != 16) begin errors++; $display("FAIL rmc_latency got %0d want 16", n); end
        a_en0 = 1; a_addr0 = 4'd12;
        tick();
        checks++; if (a_dout0 !== 32'h0) begin errors++; $display("FAIL rmc_addr12 got %h want 0", a_dout0); end
        a_addr0 = 4'd0;
        tick();
        checks++; if (a_dout0 !== 32'h0) begin errors++; $display("FAIL rmc_addr0 got %h want 0", a_dout0); end
        idle_all();
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_byte_write();
        test_rdw();
        test_collision();
        test_back_to_back();
        test_reset_mid_access();
`ifdef BDRAM_INIT_CLEAR_EN
        test_init_clear();
        test_reset_mid_clear();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bdram_dp.md
# bdram_dp

Parametrised dual-port block RAM for the SoC SRAM path. It generalises the single-port 32-bit byte-write RAM in three ways: configurable word width and depth, a second read-only port for instruction fetch, and defined read-during-write and port-collision behaviour. Port A serves data load/store with byte strobes; port B serves instruction fetch. An optional post-reset zero-fill engine guarantees known memory contents.

## Interface
- DATA_W, 32: word width in bits; must be a multiple of 8, minimum 8.
- ADDR_W, 16: word-address width; depth is 2**ADDR_W.
- RD_MODE, 0: read-during-write policy. 0 = read-first (old data). 1 = write-first (merged new data).

- clka  in  1  clock; all logic is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- init_done  out  1  memory accepts requests while this is high.
- a_en  in  1  port A access request.
- a_we  in  DATA_W/8  port A byte write strobes; all zero means a read.
- a_addr  in  ADDR_W  port A word address.
- a_din  in  DATA_W  port A write data.
- a_dout  out  DATA_W  port A read data, registered.
- a_valid  out  1  pulses when a_dout is updated.
- b_en  in  1  port B read request.
- b_addr  in  ADDR_W  port B word address.
- b_dout  out  DATA_W  port B read data, registered.
- b_valid  out  1  pulses when b_dout is updated.

## Operation
- Port A accepts a request in a cycle when a_en=1 and init_done=1.
  - A write updates only the bytes whose strobe is set; all other bytes keep their value.
  - a_dout always reports a word, including on writes:
    - RD_MODE=0: the pre-write word.
    - RD_MODE=1: the merged post-write word.
  - Writes never echo raw a_din.
- Port B accepts a request in a cycle when b_en=1 and init_done=1. It only reads.
- Collision (both ports accepted, same address, port A writing): b_dout follows RD_MODE exactly as a_dout does. Port B never returns a partially merged word.
- When a port does not accept a request:
  - its dout holds its last value;
  - its valid is 0;
  - memory contents are unchanged.
- Memory contents are not affected by resetn.

## Timing
- Read latency is 1 cycle: a request accepted at edge N updates dout and pulses valid for one cycle after edge N.
- Back-to-back requests are accepted every cycle, giving full throughput on both ports.
- Reset values: a_dout=0, b_dout=0, a_valid=0, b_valid=0, init_done=0. Clear state = CLEAR, clear counter = 0.
- Requests presented while init_done=0 are dropped. They are not queued.
- Reset asserted at any time, including mid-clear or mid-access:
  - all outputs return to their reset values immediately;
  - any write in that cycle is suppressed.

## Configuration
- Macro BDRAM_INIT_CLEAR_EN.
- Defined: two-state FSM, CLEAR then READY.
  - CLEAR writes zero to mem[cnt] and increments cnt each cycle after reset release.
  - After writing address 2**ADDR_W-1, the FSM enters READY and init_done rises on the following edge. This is 2**ADDR_W cycles after reset release.
  - The counter is ADDR_W bits. Its wrap is never reached because the FSM leaves CLEAR on the last address.
  - Reset during CLEAR restarts the fill at address 0.
- Not defined: no fill engine.
  - init_done rises on the first rising edge after resetn deasserts.
  - Memory contents are undefined until written or loaded by $readmemh.

## Test plan
- Byte-strobe write, ADDR_W=4, RD_MODE=0:
  - write 0x11223344 to address 3 with a_we=4'hF;
  - then write 0xAABBCCDD to address 3 with a_we=4'b0101;
  - port A read of address 3 -> a_dout=0x11BB33DD, one cycle after the request.
- Read-during-write on port A, address 5 holding 0x0000_0001:
  - write 0xDEADBEEF with all strobes;
  - RD_MODE=0 -> a_dout=0x00000001;
  - RD_MODE=1 -> a_dout=0xDEADBEEF;
  - both cases: a subsequent read returns 0xDEADBEEF.
- Port collision:
  - same cycle: A writes 0x12345678 to address 7 (old value 0xFFFFFFFF), B reads address 7;
  - RD_MODE=0 -> b_dout=0xFFFFFFFF;
  - RD_MODE=1 -> b_dout=0x12345678.
- Init clear, BDRAM_INIT_CLEAR_EN defined, ADDR_W=4:
  - preload 0xA5A5A5A5 everywhere, release reset;
  - init_done rises 16 cycles later;
  - reads of addresses 0..15 -> 0;
  - a_en pulsed during the clear -> no a_valid.
- Reset mid-clear:
  - assert resetn=0 at clear count 9, release it;
  - init_done rises a full 16 cycles after the second release;
  - all douts and valids are 0 while reset is low.
- Throughput and hold, DATA_W=64:
  - stream port B reads of addresses 0..7 on consecutive cycles -> b_valid high for 8 consecutive cycles with the correct words;
  - then drop b_en -> b_dout holds the last word and b_valid=0.
